// File: rtl/splitter_seq_if.sv
// ---------------------------------------------------------------------------
// splitter_seq_if
// Word-in / byte-out stream bundle for the word splitter sequencer.
//   in_valid  : producer has a word
//   in_ready  : sequencer can accept a word this cycle
//   in_word   : 32-bit word, lanes O1=[31:24] O2=[23:16] O3=[15:8] O4=[7:0]
//   in_mask   : lane enable, bit3=O1 .. bit0=O4
//   out_valid : out_data holds a byte
//   out_ready : consumer takes the byte this cycle
//   out_data  : current byte
//   out_idx   : lane of the current byte (0=O1 .. 3=O4)
//   out_last  : current byte is the last enabled byte of its word
// master = word producer / byte consumer side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface splitter_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic [3:0]  in_mask;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_idx;
    logic        out_last;

    modport master (
        output in_valid, in_word, in_mask, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_word, in_mask, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last
    );
endinterface

// File: rtl/splitter_seq.sv
// ---------------------------------------------------------------------------
// splitter_seq
// Sequencer for the 32-bit word splitter. Accepts one word per handshake and
// emits its enabled byte lanes one per cycle on a byte stream, in O1..O4 order
// (MSB_FIRST=1) or O4..O1 order (MSB_FIRST=0). Disabled lanes cost no cycles.
// A new word may be accepted in the same cycle as the last byte handshake so
// consecutive words stream without a bubble.
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous reset, active low
//   bus       : word-in / byte-out stream bundle (slave side)
//   err_empty : 1-cycle pulse after a word is accepted with an all-zero mask
//   word_cnt  : count of words fully emitted, wraps at 2^CNT_W
// ---------------------------------------------------------------------------
module splitter_seq #(
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    splitter_seq_if.slave     bus,
    output logic              err_empty,
    output logic [CNT_W-1:0]  word_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Lane number occupying a given position of the emission order.
    function automatic logic [1:0] lane_at(input logic [1:0] pos);
        return MSB_FIRST ? pos : (2'd3 - pos);
    endfunction

    // First enabled lane in emission order; en is indexed by lane (bit0 = O1).
    function automatic logic [1:0] first_lane(input logic [3:0] en);
        logic [1:0] lane;
        lane = 2'd0;
        // Walk positions from last to first so the earliest enabled one wins.
        for (int p = 3; p >= 0; p--) begin
            if (en[lane_at(2'(p))]) begin
                lane = lane_at(2'(p));
            end else begin
                lane = lane;
            end
        end
        return lane;
    endfunction

    // Byte held in a lane of a word.
    function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            2'd3:    b = word[7:0];
            default: b = 8'd0;
        endcase
        return b;
    endfunction

    // One-hot lane selector.
    function automatic logic [3:0] lane_bit(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

    state_t           state_r,     state_nxt_s;
    logic [31:0]      word_r,      word_nxt_s;
    logic [3:0]       pend_r,      pend_nxt_s;     // lanes still to emit after the current one
    logic             out_valid_r, out_valid_nxt_s;
    logic [7:0]       out_data_r,  out_data_nxt_s;
    logic [1:0]       out_idx_r,   out_idx_nxt_s;
    logic             out_last_r,  out_last_nxt_s;
    logic             err_r,       err_nxt_s;
    logic [CNT_W-1:0] cnt_r,       cnt_nxt_s;

    logic             hs_adv_s;
    logic             hs_last_s;
    logic             in_ready_s;
    logic             accept_s;
    logic [3:0]       lane_en_s;
    logic [1:0]       in_first_s;
    logic [3:0]       in_rem_s;
    logic [1:0]       pend_first_s;
    logic [3:0]       pend_rem_s;

    assign hs_adv_s   = out_valid_r & bus.out_ready & ~out_last_r;
    assign hs_last_s  = out_valid_r & bus.out_ready & out_last_r;
    assign in_ready_s = (state_r == ST_IDLE) | hs_last_s;
    assign accept_s   = bus.in_valid & in_ready_s;

    // Re-index the mask by lane number: mask bit3 is lane O1 (lane 0).
    assign lane_en_s    = {bus.in_mask[0], bus.in_mask[1], bus.in_mask[2], bus.in_mask[3]};
    assign in_first_s   = first_lane(lane_en_s);
    assign in_rem_s     = lane_en_s & ~lane_bit(in_first_s);
    assign pend_first_s = first_lane(pend_r);
    assign pend_rem_s   = pend_r & ~lane_bit(pend_first_s);

    // Next-state and next-output decode.
    always_comb begin
        state_nxt_s     = state_r;
        word_nxt_s      = word_r;
        pend_nxt_s      = pend_r;
        out_valid_nxt_s = out_valid_r;
        out_data_nxt_s  = out_data_r;
        out_idx_nxt_s   = out_idx_r;
        out_last_nxt_s  = out_last_r;
        err_nxt_s       = 1'b0;
        cnt_nxt_s       = cnt_r;

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    word_nxt_s = bus.in_word;
                    if (bus.in_mask != 4'd0) begin
                        state_nxt_s     = ST_SEND;
                        out_valid_nxt_s = 1'b1;
                        out_data_nxt_s  = lane_byte(bus.in_word, in_first_s);
                        out_idx_nxt_s   = in_first_s;
                        pend_nxt_s      = in_rem_s;
                        out_last_nxt_s  = (in_rem_s == 4'd0);
                    end else begin
                        err_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end

            ST_SEND: begin
                if (hs_adv_s) begin
                    out_data_nxt_s = lane_byte(word_r, pend_first_s);
                    out_idx_nxt_s  = pend_first_s;
                    pend_nxt_s     = pend_rem_s;
                    out_last_nxt_s = (pend_rem_s == 4'd0);
                end else if (hs_last_s) begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                    if (accept_s && (bus.in_mask != 4'd0)) begin
                        // Chain straight into the next word: no idle cycle.
                        word_nxt_s      = bus.in_word;
                        out_data_nxt_s  = lane_byte(bus.in_word, in_first_s);
                        out_idx_nxt_s   = in_first_s;
                        pend_nxt_s      = in_rem_s;
                        out_last_nxt_s  = (in_rem_s == 4'd0);
                    end else begin
                        if (accept_s) begin
                            word_nxt_s = bus.in_word;
                            err_nxt_s  = 1'b1;
                        end else begin
                            err_nxt_s  = 1'b0;
                        end
                        state_nxt_s     = ST_IDLE;
                        out_valid_nxt_s = 1'b0;
                        out_last_nxt_s  = 1'b0;
                        pend_nxt_s      = 4'd0;
                    end
                end else begin
                    // Stalled by the consumer: hold the presented byte.
                    state_nxt_s = ST_SEND;
                end
            end

            default: begin
                state_nxt_s     = ST_IDLE;
                out_valid_nxt_s = 1'b0;
                out_last_nxt_s  = 1'b0;
                pend_nxt_s      = 4'd0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            word_r      <= 32'd0;
            pend_r      <= 4'd0;
            out_valid_r <= 1'b0;
            out_data_r  <= 8'd0;
            out_idx_r   <= 2'd0;
            out_last_r  <= 1'b0;
            err_r       <= 1'b0;
            cnt_r       <= '0;
        end else begin
            state_r     <= state_nxt_s;
            word_r      <= word_nxt_s;
            pend_r      <= pend_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_data_r  <= out_data_nxt_s;
            out_idx_r   <= out_idx_nxt_s;
            out_last_r  <= out_last_nxt_s;
            err_r       <= err_nxt_s;
            cnt_r       <= cnt_nxt_s;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_idx   = out_idx_r;
    assign bus.out_last  = out_last_r;
    assign err_empty     = err_r;
    assign word_cnt      = cnt_r;

endmodule

// File: tb/tb_splitter_seq.sv
// ---------------------------------------------------------------------------
// tb_splitter_seq
// Drives two sequencers with identical stimulus: dut1 (MSB_FIRST=1, 16-bit
// counter) and dut0 (MSB_FIRST=0, 4-bit counter so wrap-around is reached).
// The producer pushes the expected byte list of every accepted word into a
// per-DUT queue; a monitor on the falling edge compares the presented bytes,
// in_ready, err_empty and word_cnt against those queues.
// ---------------------------------------------------------------------------
module tb_splitter_seq;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] idx;
        logic       last;
    } exp_t;

    logic clk;
    logic rst_n;
    logic in_valid;
    logic out_ready;
    logic [31:0] in_word;
    logic [3:0]  in_mask;
    logic        err1, err0;
    logic [15:0] cnt1;
    logic [3:0]  cnt0;

    splitter_seq_if bus1 ();
    splitter_seq_if bus0 ();

    assign bus1.in_valid  = in_valid;
    assign bus1.in_word   = in_word;
    assign bus1.in_mask   = in_mask;
    assign bus1.out_ready = out_ready;
    assign bus0.in_valid  = in_valid;
    assign bus0.in_word   = in_word;
    assign bus0.in_mask   = in_mask;
    assign bus0.out_ready = out_ready;

    splitter_seq #(.MSB_FIRST(1'b1), .CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .err_empty(err1), .word_cnt(cnt1)
    );
    splitter_seq #(.MSB_FIRST(1'b0), .CNT_W(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .err_empty(err0), .word_cnt(cnt0)
    );

    // Per-DUT views for the monitor (index 1 = MSB first, 0 = LSB first)
    logic [1:0]  mv, ml, mrdy, merr;
    logic [7:0]  md [2];
    logic [1:0]  mi [2];
    logic [15:0] wc [2];
    logic [15:0] wmask [2];
    assign mv   = {bus1.out_valid, bus0.out_valid};
    assign ml   = {bus1.out_last,  bus0.out_last};
    assign mrdy = {bus1.in_ready,  bus0.in_ready};
    assign merr = {err1, err0};
    assign md[1] = bus1.out_data;  assign md[0] = bus0.out_data;
    assign mi[1] = bus1.out_idx;   assign mi[0] = bus0.out_idx;
    assign wc[1] = cnt1;           assign wc[0] = {12'd0, cnt0};
    assign wmask[1] = 16'hFFFF;    assign wmask[0] = 16'h000F;

    exp_t q [2][$];
    int   exp_cnt [2];
    int   err_seen [2];
    int   empty_acc;
    int   n_chk;
    int   n_fail;
    bit   pat [$];
    bit   rnd_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d at %0t: got %h expected %h", nm, d, $time, act, exp);
        end
    endtask

    // Reference model: enabled lanes in emission order, last flag on the final one.
    task automatic model_push(input logic [31:0] w, input logic [3:0] m);
        exp_t lst [$];
        exp_t e;
        int   lane;
        if (m == 4'd0) begin
            empty_acc++;
        end else begin
            for (int d = 0; d < 2; d++) begin
                lst = {};
                for (int p = 0; p < 4; p++) begin
                    lane = (d == 1) ? p : 3 - p;
                    if (m[3 - lane]) begin
                        e.data = w[31 - 8 * lane -: 8];
                        e.idx  = lane[1:0];
                        e.last = 1'b0;
                        lst.push_back(e);
                    end
                end
                lst[lst.size() - 1].last = 1'b1;
                foreach (lst[k]) q[d].push_back(lst[k]);
            end
        end
    endtask

    // Advance one clock and set the consumer's ready for the new cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        if (pat.size() > 0) out_ready = pat.pop_front();
        else if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
        else out_ready = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_word(input logic [31:0] w, input logic [3:0] m);
        int t;
        in_valid = 1'b1;
        in_word  = w;
        in_mask  = m;
        t = 0;
        forever begin
            @(negedge clk);
            if (bus1.in_ready) break;
            t++;
            if (t > 200) begin
                chk("accept_timeout", 1, 32'd1, 32'd0);
                in_valid = 1'b0;
                return;
            end
            tick();
        end
        tick();
        model_push(w, m);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q[0].size() != 0 || q[1].size() != 0) && t < 200) begin
            tick();
            t++;
        end
        if (t >= 200) chk("drain_timeout", 1, 32'd1, 32'd0);
        idle(2);
    endtask

    task automatic chk_reset_state();
        chk("rst_out_valid", 1, {31'd0, bus1.out_valid}, 32'd0);
        chk("rst_out_data",  1, {24'd0, bus1.out_data},  32'd0);
        chk("rst_out_idx",   1, {30'd0, bus1.out_idx},   32'd0);
        chk("rst_out_last",  1, {31'd0, bus1.out_last},  32'd0);
        chk("rst_err_empty", 1, {31'd0, err1},           32'd0);
        chk("rst_word_cnt",  1, {16'd0, cnt1},           32'd0);
        chk("rst_word_cnt",  0, {28'd0, cnt0},           32'd0);
        chk("rst_in_ready",  1, {31'd0, bus1.in_ready},  32'd1);
        chk("rst_out_valid", 0, {31'd0, bus0.out_valid}, 32'd0);
    endtask

    // Scoreboard monitor, sampling away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        logic ev;
        logic erdy;
        logic eerr;
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                ev = (q[d].size() != 0);
                chk("out_valid", d, {31'd0, mv[d]}, {31'd0, ev});
                if (ev && mv[d]) begin
                    e = q[d][0];
                    chk("out_data", d, {24'd0, md[d]}, {24'd0, e.data});
                    chk("out_idx",  d, {30'd0, mi[d]}, {30'd0, e.idx});
                    chk("out_last", d, {31'd0, ml[d]}, {31'd0, e.last});
                end
                erdy = !ev || (out_ready && q[d][0].last);
                chk("in_ready", d, {31'd0, mrdy[d]}, {31'd0, erdy});
                chk("word_cnt", d, {16'd0, wc[d]}, {16'd0, exp_cnt[d][15:0] & wmask[d]});
                eerr = (empty_acc != err_seen[d]);
                chk("err_empty", d, {31'd0, merr[d]}, {31'd0, eerr});
                if (eerr) err_seen[d]++;
                if (ev && out_ready) begin
                    if (q[d][0].last) exp_cnt[d]++;
                    void'(q[d].pop_front());
                end
            end
        end
    end

    initial begin
        n_chk = 0; n_fail = 0; empty_acc = 0;
        exp_cnt = '{0, 0}; err_seen = '{0, 0};
        rnd_ready = 1'b0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_word = 32'd0; in_mask = 4'd0;
        idle(2);
        chk_reset_state();
        rst_n = 1'b1;
        idle(2);

        // Full word, consumer always ready
        send_word(32'hF1A5A077, 4'hF);
        drain();
        // Consumer stalls three cycles while the second byte is shown
        pat = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        send_word(32'hF1A5A077, 4'hF);
        drain();
        // Sparse mask
        send_word(32'hF1A5A077, 4'b1010);
        drain();
        // Back-to-back words, second one accepted on the last handshake
        send_word(32'hF1A5A077, 4'hF);
        send_word(32'h01020304, 4'hF);
        drain();
        // Empty mask from idle, then chained after a word
        send_word(32'hDEADBEEF, 4'h0);
        idle(3);
        send_word(32'h11223344, 4'h1);
        send_word(32'h55667788, 4'h0);
        drain();

        // Reset in the middle of a word
        send_word(32'hF1A5A077, 4'hF);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk_reset_state();
        q[0] = {}; q[1] = {};
        exp_cnt = '{0, 0}; err_seen = '{0, 0}; empty_acc = 0;
        tick();
        tick();
        rst_n = 1'b1;
        idle(1);
        send_word(32'h01020304, 4'hF);
        drain();

        // Randomized traffic with a throttling consumer; long enough to wrap dut0's counter
        rnd_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send_word($urandom, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        drain();
        chk("final_word_cnt", 0, {28'd0, cnt0}, exp_cnt[0] & 32'h0000000F);
        chk("final_word_cnt", 1, {16'd0, cnt1}, exp_cnt[1] & 32'h0000FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
